// File: rtl/dec_bit_collector.sv
// dec_bit_collector: packs SEG_W-bit node segments MSB-first into an
// N-bit frame and hands the frame downstream over valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_start       pulse: begin a new frame (clears the buffer)
//   seg_valid/ready   segment handshake; seg_bits data, seg_zero rate-0 node
//   frame_valid/ready frame handshake; frame_bits holds the assembled frame
//   seg_cnt           segments accepted in the current frame
//   busy              high while collecting or presenting a frame
//   abort_err         one-cycle pulse when a frame is restarted mid-collect
module dec_bit_collector #(
    parameter int N     = 256,
    parameter int SEG_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             seg_valid,
    output logic             seg_ready,
    input  logic [SEG_W-1:0] seg_bits,
    input  logic             seg_zero,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [N-1:0]     frame_bits,
    output logic [CNT_W-1:0] seg_cnt,
    output logic             busy,
    output logic             abort_err
);

    localparam int NSEG = N / SEG_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_frame;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;

    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic [SEG_W-1:0] w_seg;
    logic [N-1:0]     w_frame_nxt;

    assign seg_ready   = (r_state == COLLECT);
    assign frame_valid = (r_state == OUT);
    assign busy        = (r_state != IDLE);
    assign frame_bits  = r_frame;
    assign seg_cnt     = r_cnt;
    assign abort_err   = r_abort;

    assign w_accept  = seg_valid & seg_ready;
    assign w_release = frame_valid & frame_ready;
    assign w_last    = (r_cnt == CNT_W'(NSEG - 1));
    assign w_seg     = seg_zero ? '0 : seg_bits;

    // Slot selected by the current count; segment 0 lands in the MSBs.
    always_comb begin
        w_frame_nxt = r_frame;
        for (int s = 0; s < NSEG; s++) begin
            if (r_cnt == CNT_W'(s)) begin
                w_frame_nxt[N-1-s*SEG_W -: SEG_W] = w_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_state <= COLLECT;
                        r_frame <= '0;
                        r_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    // A restart wins over a simultaneous segment.
                    if (frame_start) begin
                        r_frame <= '0;
                        r_cnt   <= '0;
                        r_abort <= 1'b1;
                    end else if (w_accept) begin
                        r_frame <= w_frame_nxt;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (w_release) begin
                        if (frame_start) begin
                            r_state <= COLLECT;
                            r_frame <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bit_collector.sv
// tb_dec_bit_collector: directed + random stimulus for dec_bit_collector,
// checked against a queue-based model of the collected frame.
module tb_dec_bit_collector;

    localparam int N     = 32;
    localparam int SEG_W = 8;
    localparam int CNT_W = 6;
    localparam int NSEG  = N / SEG_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_start;
    logic             seg_valid;
    logic             seg_ready;
    logic [SEG_W-1:0] seg_bits;
    logic             seg_zero;
    logic             frame_valid;
    logic             frame_ready;
    logic [N-1:0]     frame_bits;
    logic [CNT_W-1:0] seg_cnt;
    logic             busy;
    logic             abort_err;

    int total = 0;
    int bad   = 0;

    // Model: the frame is just the list of accepted segments.
    logic [7:0] m_q[$];
    bit         m_known = 0;
    bit         m_coll  = 0;
    bit         m_out   = 0;
    bit         m_abort = 0;

    dec_bit_collector #(.N(N), .SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .seg_bits    (seg_bits),
        .seg_zero    (seg_zero),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_bits  (frame_bits),
        .seg_cnt     (seg_cnt),
        .busy        (busy),
        .abort_err   (abort_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack();
        logic [31:0] f;
        f = 32'h0;
        foreach (m_q[i]) f = f | (32'(m_q[i]) << (24 - 8 * i));
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        if (!m_known) return;
        chk("seg_ready",   32'(seg_ready),   32'(m_coll));
        chk("frame_valid", 32'(frame_valid), 32'(m_out));
        chk("busy",        32'(busy),        32'(m_coll | m_out));
        chk("abort_err",   32'(abort_err),   32'(m_abort));
        chk("seg_cnt",     32'(seg_cnt),     32'(m_q.size()));
        chk("frame_bits",  frame_bits,       pack());
    endtask

    task automatic model(input bit r, input bit st, input bit sv,
                         input bit sz, input logic [7:0] sb,
                         input bit fr);
        if (r) begin
            m_known = 1;
            m_coll  = 0;
            m_out   = 0;
            m_abort = 0;
            m_q.delete();
            return;
        end
        m_abort = 0;
        if (m_coll) begin
            if (st) begin
                m_q.delete();
                m_abort = 1;
            end else if (sv) begin
                m_q.push_back(sz ? 8'h00 : sb);
                if (m_q.size() == NSEG) begin
                    m_coll = 0;
                    m_out  = 1;
                end
            end
        end else if (m_out) begin
            if (fr) begin
                m_out = 0;
                if (st) begin
                    m_coll = 1;
                    m_q.delete();
                end
            end
        end else if (st) begin
            m_coll = 1;
            m_q.delete();
        end
    endtask

    // One clock: drive, check pre-edge outputs, advance model, clock.
    task automatic cyc(input bit r, input bit st, input bit sv,
                       input bit sz, input logic [7:0] sb,
                       input bit fr);
        rst         = r;
        frame_start = st;
        seg_valid   = sv;
        seg_zero    = sz;
        seg_bits    = sb;
        frame_ready = fr;
        #1;
        chk_all();
        model(r, st, sv, sz, sb, fr);
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic [7:0] b, input bit fr);
        cyc(0, 0, 1, 0, b, fr);
    endtask

    initial begin
        rst = 1; frame_start = 0; seg_valid = 0;
        seg_bits = 0; seg_zero = 0; frame_ready = 0;
        @(posedge clk);
        #1;

        // reset
        cyc(1, 1, 1, 0, 8'hFF, 1);
        chk("rst_frame", frame_bits, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(seg_ready), 32'h0);

        // basic frame
        cyc(0, 1, 0, 0, 8'h00, 1);
        seg(8'hA5, 1);
        seg(8'h3C, 1);
        seg(8'hFF, 1);
        chk("basic_not_yet", 32'(frame_valid), 32'h0);
        seg(8'h01, 1);
        chk("basic_valid", 32'(frame_valid), 32'h1);
        chk("basic_frame", frame_bits, 32'hA53CFF01);
        chk("basic_cnt", 32'(seg_cnt), 32'd4);
        cyc(0, 0, 0, 0, 8'h00, 1);
        chk("basic_idle", 32'(busy), 32'h0);

        // rate-0 and gaps
        cyc(0, 1, 0, 0, 8'h00, 0);
        seg(8'h12, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        cyc(0, 0, 1, 1, 8'hEE, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        seg(8'h34, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        cyc(0, 0, 0, 0, 8'h99, 0);
        seg(8'h56, 0);
        chk("rate0_frame", frame_bits, 32'h12003456);
        cyc(0, 0, 0, 0, 8'h00, 1);

        // backpressure
        cyc(0, 1, 0, 0, 8'h00, 0);
        seg(8'h11, 0);
        seg(8'h22, 0);
        seg(8'h33, 0);
        seg(8'h44, 0);
        for (int i = 0; i < 5; i++) seg(8'h77, 0);
        chk("bp_frame", frame_bits, 32'h11223344);
        chk("bp_valid", 32'(frame_valid), 32'h1);
        cyc(0, 0, 1, 0, 8'h77, 1);
        chk("bp_released", 32'(frame_valid), 32'h0);

        // abort
        cyc(0, 1, 0, 0, 8'h00, 0);
        seg(8'hAA, 0);
        seg(8'hBB, 0);
        cyc(0, 1, 1, 0, 8'hCC, 0);
        chk("abort_pulse", 32'(abort_err), 32'h1);
        chk("abort_cnt", 32'(seg_cnt), 32'h0);
        seg(8'h01, 0);
        chk("abort_once", 32'(abort_err), 32'h0);
        seg(8'h02, 0);
        seg(8'h03, 0);
        seg(8'h04, 0);
        chk("abort_frame", frame_bits, 32'h01020304);

        // back-to-back start with release
        cyc(0, 1, 0, 0, 8'h00, 1);
        chk("b2b_busy", 32'(seg_ready), 32'h1);
        chk("b2b_noerr", 32'(abort_err), 32'h0);
        seg(8'hDE, 0);
        seg(8'hAD, 0);

        // reset mid-collect
        cyc(1, 0, 1, 0, 8'h55, 0);
        chk("midrst_frame", frame_bits, 32'h0);
        chk("midrst_cnt", 32'(seg_cnt), 32'h0);
        seg(8'h66, 1);
        seg(8'h67, 1);
        chk("midrst_ignored", 32'(seg_cnt), 32'h0);

        // random
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0),
                8'($urandom),
                ($urandom_range(0, 1) == 1));
        end
        cyc(0, 0, 0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_bit_collector.md
Name: dec_bit_collector

Overview:
- Downstream of the special-node bit functions in the decoder: consumes their SEG_W-bit decoded-bit vectors (e.g. the 8-bit {4{b1,b0}} pattern), one node at a time, over a valid/ready handshake.
- Assembles the vectors MSB-first into an N-bit frame register.
- Presents the completed frame to the output/partial-sum logic over a second valid/ready handshake.
- Decouples node-decoder timing from frame consumption; supports rate-0 (all-zero) nodes and mid-frame abort.

Parameters:
- N, 256, frame length in bits; must be a multiple of SEG_W.
- SEG_W, 8, bits per node segment; equals the special-node bit bus width.
- CNT_W, 6, segment counter width; must be at least ceil(log2(N/SEG_W + 1)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse that starts a new frame and clears the buffer
- seg_valid  in  1  segment on seg_bits/seg_zero is valid
- seg_ready  out  1  collector accepts a segment this cycle
- seg_bits  in  SEG_W  decoded bits of the node
- seg_zero  in  1  rate-0 node: write zeros and ignore seg_bits
- frame_valid  out  1  frame_bits holds a complete frame
- frame_ready  in  1  consumer accepts the frame
- frame_bits  out  N  assembled frame; first segment in [N-1 -: SEG_W]
- seg_cnt  out  CNT_W  number of segments accepted in the current frame
- busy  out  1  high in COLLECT or OUT
- abort_err  out  1  one-cycle pulse when frame_start arrives mid-COLLECT

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, seg_ready=0, frame_valid=0, frame_bits=0, seg_cnt=0, busy=0, abort_err=0. Reset overrides every other input in the same cycle.
- NSEG = N/SEG_W. Accept = seg_valid & seg_ready. Release = frame_valid & frame_ready.
- States: IDLE, COLLECT, OUT.
- IDLE:
  - seg_ready=0.
  - frame_start -> next cycle COLLECT, with frame_bits=0 and seg_cnt=0.
  - seg_valid is ignored.
- COLLECT:
  - seg_ready=1 (combinational from state only; no dependency on seg_valid).
  - On accept: frame_bits[N-1-seg_cnt*SEG_W -: SEG_W] <= (seg_zero ? 0 : seg_bits); seg_cnt <= seg_cnt+1. All other bits unchanged.
  - On the accept that makes seg_cnt==NSEG: next state OUT, registered, so frame_valid rises the cycle after the last accept.
  - frame_start in COLLECT (with or without a simultaneous accept): the segment is discarded, frame_bits<=0, seg_cnt<=0, state stays COLLECT, abort_err=1 for one cycle (registered).
- OUT:
  - frame_valid=1, seg_ready=0. frame_bits and seg_cnt (=NSEG) are held stable until release.
  - Release without frame_start: next IDLE; frame_bits keeps its value, seg_cnt keeps NSEG until the next start.
  - Release with frame_start in the same cycle: next COLLECT, frame_bits=0, seg_cnt=0, no abort_err.
  - frame_start without release: ignored, no error.
- busy = (state != IDLE).
- Latency: last segment accept to frame_valid is 1 cycle. Release to next segment acceptance is 1 cycle (back-to-back start) or 2 cycles (start after returning to IDLE). Sustained throughput is 1 segment per cycle.
- seg_cnt never exceeds NSEG; no write is possible outside COLLECT.

Test Plan:
- N=32, SEG_W=8, CNT_W=6 for all scenarios.
- Basic frame: rst, start, then 4 back-to-back segments 0xA5, 0x3C, 0xFF, 0x01 with frame_ready=1 -> frame_valid high exactly 1 cycle after the 4th accept, frame_bits=0xA53CFF01, seg_cnt=4, then IDLE with busy=0.
- Rate-0 and gaps: segments 0x12, (seg_zero=1, seg_bits=0xEE), 0x34, 0x56 with seg_valid deasserted 2 cycles between each -> frame_bits=0x12003456; seg_cnt increments only on accepts.
- Backpressure: complete frame 0x11223344 with frame_ready=0 for 5 cycles while seg_valid=1 -> seg_ready=0 throughout, frame_bits stable, single release on frame_ready rise.
- Abort: 2 segments (0xAA, 0xBB), then frame_start together with seg_valid -> abort_err pulse 1 cycle, seg_cnt=0; then 0x01, 0x02, 0x03, 0x04 -> frame_bits=0x01020304.
- Back-to-back frames and reset: frame_start together with release -> second frame collects with no IDLE cycle and no abort_err; assert rst mid-COLLECT -> all outputs at reset values next cycle, seg_valid ignored until a new frame_start.
